// File: rtl/clint_vec_pkg.sv
// Shared encodings for the vectored interrupt controller: FSM states,
// mstatus bit positions, exception cause codes and CSR write strobe bits.
package clint_vec_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_MSTATUS = 3'd1;
    localparam logic [2:0] ST_MEPC    = 3'd2;
    localparam logic [2:0] ST_MCAUSE  = 3'd3;
    localparam logic [2:0] ST_ASSERT  = 3'd4;
    localparam logic [2:0] ST_MRET    = 3'd5;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int CAUSE_ECALL  = 11;

    localparam int WE_MSTATUS = 0;
    localparam int WE_MEPC    = 1;
    localparam int WE_MCAUSE  = 2;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clint_prio_enc.sv
// Fixed-priority encoder over pending & mask; the lowest set index wins.
module clint_prio_enc
    import clint_vec_pkg::*;
#(
    parameter int NUM_INT = 8,
    parameter int IDX_W   = idx_width(NUM_INT)
) (
    input  logic [NUM_INT-1:0] pending,
    input  logic [NUM_INT-1:0] mask,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    logic [NUM_INT-1:0] req;

    assign req = pending & mask;

    // Scan downward so the last hit, the lowest index, is kept.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/clint_vec.sv
// Interrupt/trap sequencer: arbitrates ecall, mret and masked interrupt lines,
// writes mstatus/mepc/mcause one per cycle, then redirects fetch.
//
// state   | meaning
// IDLE    | arbitrate new requests
// MSTATUS | write mstatus (MPIE<=MIE, MIE<=0)
// MEPC    | write saved PC
// MCAUSE  | write cause
// ASSERT  | redirect fetch, flush, claim line
// MRET    | write mstatus (MIE<=MPIE, MPIE<=1)
module clint_vec
    import clint_vec_pkg::*;
#(
    parameter int                 NUM_INT    = 8,
    parameter int                 DATA_W     = 32,
    parameter int                 ADDR_W     = 32,
    parameter logic [NUM_INT-1:0] EDGE_MASK  = '0,
    parameter int                 INST_BYTES = 4,
    parameter int                 CAUSE_BASE = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_INT-1:0] int_flag,
    input  logic [NUM_INT-1:0] int_mask,
    input  logic               sync_ecall,
    input  logic               sync_mret,
    input  logic [ADDR_W-1:0]  inst_addr,
    input  logic               jump_flag,
    input  logic [ADDR_W-1:0]  jump_addr,
    input  logic [DATA_W-1:0]  csr_mtvec,
    input  logic [DATA_W-1:0]  csr_mepc,
    input  logic [DATA_W-1:0]  csr_mstatus,
    output logic               hold_flag,
    output logic               clear_flag_int,
    output logic [2:0]         int_we,
    output logic [DATA_W-1:0]  int_mstatus,
    output logic [DATA_W-1:0]  int_mepc,
    output logic [DATA_W-1:0]  int_mcause,
    output logic [ADDR_W-1:0]  int_inst_addr,
    output logic               int_assert,
    output logic [NUM_INT-1:0] int_claim
);

    localparam int IDX_W = idx_width(NUM_INT);

    logic [2:0]         state;
    logic [NUM_INT-1:0] flag_q;
    logic [NUM_INT-1:0] edge_pend;
    logic [NUM_INT-1:0] pending;
    logic [NUM_INT-1:0] claim_vec;
    logic [NUM_INT-1:0] claim_clr;
    logic               req_valid;
    logic [IDX_W-1:0]   req_idx;
    logic               irq_go;
    logic [DATA_W-2:0]  irq_code;
    logic [DATA_W-1:0]  cause_q;
    logic [ADDR_W-1:0]  epc_q;
    logic [IDX_W-1:0]   idx_q;
    logic               async_q;
    logic               mret_q;
    logic [DATA_W-1:0]  ms_trap;
    logic [DATA_W-1:0]  ms_mret;
    logic [DATA_W-1:0]  trap_base;
    logic [DATA_W-1:0]  trap_full;
    logic [ADDR_W-1:0]  trap_target;

    assign pending   = (edge_pend & EDGE_MASK) | (int_flag & ~EDGE_MASK);
    assign irq_go    = req_valid & csr_mstatus[MSTATUS_MIE];
    assign irq_code  = (DATA_W-1)'(CAUSE_BASE) + (DATA_W-1)'(req_idx);
    assign claim_vec = async_q ? (NUM_INT'(1) << idx_q) : '0;
    assign claim_clr = (state == ST_ASSERT) ? claim_vec : '0;
    assign hold_flag = (state != ST_IDLE);

    clint_prio_enc #(
        .NUM_INT (NUM_INT),
        .IDX_W   (IDX_W)
    ) u_prio (
        .pending (pending),
        .mask    (int_mask),
        .valid   (req_valid),
        .idx     (req_idx)
    );

    always_comb begin
        ms_trap               = csr_mstatus;
        ms_trap[MSTATUS_MPIE] = csr_mstatus[MSTATUS_MIE];
        ms_trap[MSTATUS_MIE]  = 1'b0;
        ms_mret               = csr_mstatus;
        ms_mret[MSTATUS_MIE]  = csr_mstatus[MSTATUS_MPIE];
        ms_mret[MSTATUS_MPIE] = 1'b1;
    end

    // Only async traps honour vectored mode; exceptions always land on the base.
    always_comb begin
        trap_base = {csr_mtvec[DATA_W-1:2], 2'b00};
        trap_full = trap_base;
        if (async_q && (csr_mtvec[1:0] == 2'b01))
            trap_full = trap_base + DATA_W'(INST_BYTES) * {1'b0, cause_q[DATA_W-2:0]};
        trap_target = trap_full[ADDR_W-1:0];
    end

    // A fresh rising edge in the claim cycle is ORed in after the clear, so it survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q    <= '0;
            edge_pend <= '0;
        end else begin
            flag_q    <= int_flag;
            edge_pend <= ((edge_pend & ~claim_clr) | (int_flag & ~flag_q)) & EDGE_MASK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cause_q <= '0;
            epc_q   <= '0;
            idx_q   <= '0;
            async_q <= 1'b0;
            mret_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sync_ecall) begin
                        state   <= ST_MSTATUS;
                        cause_q <= DATA_W'(CAUSE_ECALL);
                        epc_q   <= inst_addr;
                        async_q <= 1'b0;
                        mret_q  <= 1'b0;
                    end else if (sync_mret) begin
                        state   <= ST_MRET;
                        async_q <= 1'b0;
                        mret_q  <= 1'b1;
                    end else if (irq_go) begin
                        state   <= ST_MSTATUS;
                        cause_q <= {1'b1, irq_code};
                        epc_q   <= jump_flag ? jump_addr : inst_addr;
                        idx_q   <= req_idx;
                        async_q <= 1'b1;
                        mret_q  <= 1'b0;
                    end
                end
                ST_MSTATUS: state <= ST_MEPC;
                ST_MEPC:    state <= ST_MCAUSE;
                ST_MCAUSE:  state <= ST_ASSERT;
                ST_MRET:    state <= ST_ASSERT;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    // Outputs are registered from the current state, one cycle behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_we         <= '0;
            int_mstatus    <= '0;
            int_mepc       <= '0;
            int_mcause     <= '0;
            int_inst_addr  <= '0;
            int_assert     <= 1'b0;
            clear_flag_int <= 1'b0;
            int_claim      <= '0;
        end else begin
            int_we         <= '0;
            int_mstatus    <= '0;
            int_mepc       <= '0;
            int_mcause     <= '0;
            int_inst_addr  <= '0;
            int_assert     <= 1'b0;
            clear_flag_int <= 1'b0;
            int_claim      <= '0;
            case (state)
                ST_MSTATUS: begin
                    int_we[WE_MSTATUS] <= 1'b1;
                    int_mstatus        <= ms_trap;
                end
                ST_MEPC: begin
                    int_we[WE_MEPC] <= 1'b1;
                    int_mepc        <= DATA_W'(epc_q);
                end
                ST_MCAUSE: begin
                    int_we[WE_MCAUSE] <= 1'b1;
                    int_mcause        <= cause_q;
                end
                ST_MRET: begin
                    int_we[WE_MSTATUS] <= 1'b1;
                    int_mstatus        <= ms_mret;
                end
                ST_ASSERT: begin
                    int_assert     <= 1'b1;
                    clear_flag_int <= 1'b1;
                    int_claim      <= claim_vec;
                    int_inst_addr  <= mret_q ? csr_mepc[ADDR_W-1:0] : trap_target;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/clint_vec.md
Name: clint_vec

Overview:
- Parametrised successor to the core's single-flag interrupt controller.
- Accepts NUM_INT interrupt lines, each individually maskable and configurable as level- or edge-triggered, with fixed priority (index 0 highest).
- Also services synchronous ecall and mret.
- Sequences the mstatus/mepc/mcause CSR writes, stalls the pipeline, then redirects fetch to a direct or vectored trap target taken from mtvec.

Parameters:
- NUM_INT, 8, number of external interrupt lines (1..16).
- DATA_W, 32, CSR and data width.
- ADDR_W, 32, instruction address width.
- EDGE_MASK, 8'h00, per-line trigger type: bit=1 edge (rising), bit=0 level.
- INST_BYTES, 4, vector table stride in bytes.
- CAUSE_BASE, 16, mcause code for line 0; line i uses CAUSE_BASE+i.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- int_flag  in  NUM_INT  raw interrupt lines
- int_mask  in  NUM_INT  per-line enable (mie image); 1 = enabled
- sync_ecall  in  1  decoded ecall in ID
- sync_mret  in  1  decoded mret in ID
- inst_addr  in  ADDR_W  PC of the instruction in ID
- jump_flag  in  1  EX is redirecting fetch
- jump_addr  in  ADDR_W  EX redirect target
- csr_mtvec  in  DATA_W  trap base; [1:0]=01 vectored, otherwise direct
- csr_mepc  in  DATA_W  current mepc
- csr_mstatus  in  DATA_W  current mstatus (MIE bit 3, MPIE bit 7)
- hold_flag  out  1  pipeline stall request
- clear_flag_int  out  1  flush IF/ID and ID/EX
- int_we  out  3  one-hot CSR write strobe: [0] mstatus, [1] mepc, [2] mcause
- int_mstatus  out  DATA_W  mstatus write data
- int_mepc  out  DATA_W  mepc write data
- int_mcause  out  DATA_W  mcause write data
- int_inst_addr  out  ADDR_W  fetch redirect target
- int_assert  out  1  redirect strobe, one cycle
- int_claim  out  NUM_INT  one-hot; pulses with int_assert for the serviced line

Behaviour:
- Reset:
  - Asynchronous reset forces state IDLE and clears pending, all latched cause/epc, and every output to 0.
  - Reset mid-sequence abandons the trap; no partial CSR write occurs after reset release.
- Pending:
  - Edge lines set pending on a 0->1 transition; the line's previous value is registered.
  - Level lines: pending = int_flag.
  - Edge pending clears in ASSERT when that line is claimed. A new edge in the same cycle wins, so the line stays pending.
- Selection in IDLE, in priority order:
  - sync_ecall: mcause=11, mepc=inst_addr.
  - sync_mret: return path.
  - Async interrupt: lowest index i with pending & int_mask, only if csr_mstatus[3]=1. mcause={1'b1, CAUSE_BASE+i}.
  - Saved PC for async traps: jump_addr if jump_flag else inst_addr, so an in-flight branch is not lost.
- FSM IDLE -> MSTATUS -> MEPC -> MCAUSE -> ASSERT -> IDLE, one cycle per state:
  - MSTATUS: int_we=001, int_mstatus = csr_mstatus with MPIE<=MIE, MIE<=0.
  - MEPC: int_we=010, int_mepc = captured PC.
  - MCAUSE: int_we=100, int_mcause = captured cause.
  - ASSERT: int_assert=1, clear_flag_int=1, int_claim set for async.
- Trap target:
  - Direct: {mtvec[DATA_W-1:2],2'b00}.
  - Vectored async: base + INST_BYTES*(cause code).
  - Exceptions always use base.
- mret path IDLE -> MRET -> ASSERT:
  - MRET: int_we=001, int_mstatus with MIE<=MPIE, MPIE<=1.
  - ASSERT: int_inst_addr = csr_mepc.
- Timing:
  - hold_flag = (state != IDLE).
  - A request sampled at edge N gives int_assert in cycle N+4 (mret: N+2).
  - Requests arriving while not IDLE stay pending and are re-arbitrated in IDLE. No nesting, because MIE=0 after entry.
  - Masked or MIE=0 requests remain pending indefinitely; edge pending is not lost.

Decomposition:
- Shared package holds:
  - State encoding localparams.
  - MSTATUS_MIE=3 and MSTATUS_MPIE=7 bit indices.
  - CAUSE_ECALL=11.
  - int_we bit positions.
- One sub-module: clint_prio_enc, a parametrised pending/mask priority encoder returning valid plus index, combinational.
- FSM, edge detection and CSR data formation stay in clint_vec.

Test Plan:
- Reset: hold rst_n=0 with int_flag=8'hFF -> all outputs 0. Release with mstatus=0 -> no trap and state IDLE. Assert rst_n=0 in MEPC -> next cycle all outputs 0 and no mcause write.
- Priority: mstatus=32'h8, mask=8'hFF, int_flag=8'b0010_0100 (level) -> int_we 001,010,100, then int_assert at N+4. mcause=32'h8000_0012, int_claim=8'h04, int_mstatus=32'h80.
- Vectored: mtvec=32'h0000_1001, line 3 -> int_inst_addr=32'h1000+4*19=32'h104C. With mtvec=32'h1000 -> 32'h1000.
- Edge: EDGE_MASK=8'h01, pulse line 0 while mstatus MIE=0, then set MIE after 10 cycles -> trap still taken. A second edge coincident with ASSERT -> a second trap follows after mret.
- Branch shadow: jump_flag=1, jump_addr=32'h200 during selection -> int_mepc=32'h200.
- ecall/mret: sync_ecall with inst_addr=32'h40 -> mcause=11, mepc=32'h40, target=mtvec base. Then sync_mret with csr_mepc=32'h44, mstatus=32'h80 -> int_mstatus=32'h88, int_inst_addr=32'h44 at N+2.
